// File: rtl/croc_soc_ctrl_pkg.sv
// Shared constants and types for the Croc SoC control/status register block.
// Register byte offsets, word indices, the register-file struct and the
// response struct live here so the top and the bench agree on the map.
package croc_soc_ctrl_pkg;

    // Default core boot address (start of SRAM)
    localparam logic [31:0] BootAddrDefault = 32'h1000_0000;

    // Register byte offsets from the block base address
    localparam logic [31:0] SOC_CTRL_BOOTADDR_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] SOC_CTRL_FETCHEN_OFFSET    = 32'h0000_0004;
    localparam logic [31:0] SOC_CTRL_CORESTATUS_OFFSET = 32'h0000_0008;
    localparam logic [31:0] SOC_CTRL_SCRATCH0_OFFSET   = 32'h0000_0010;

    localparam int unsigned SocCtrlNumScratch = 4;

    // Word indices used by the decoder (address bits [4:2])
    localparam logic [2:0] SOC_CTRL_BOOTADDR_IDX   = SOC_CTRL_BOOTADDR_OFFSET[4:2];
    localparam logic [2:0] SOC_CTRL_FETCHEN_IDX    = SOC_CTRL_FETCHEN_OFFSET[4:2];
    localparam logic [2:0] SOC_CTRL_CORESTATUS_IDX = SOC_CTRL_CORESTATUS_OFFSET[4:2];
    localparam logic [2:0] SOC_CTRL_SCRATCH0_IDX   = SOC_CTRL_SCRATCH0_OFFSET[4:2];

    // Architectural registers as seen by the read mux and outputs
    typedef struct packed {
        logic [31:0] boot_addr;
        logic [31:0] fetch_en;
        logic [31:0] core_status;
    } soc_ctrl_regs_t;

    // Registered bus response
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } soc_ctrl_rsp_t;

endpackage

// File: rtl/croc_soc_ctrl_reg.sv
// Byte-enabled 32-bit register with a parameterised reset value.
// One instance per architectural register of croc_soc_ctrl.
module croc_soc_ctrl_reg import croc_soc_ctrl_pkg::*; #(
    parameter logic [31:0] RstVal = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    // Update only the enabled byte lanes on a write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RstVal;
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) q_o[8*b +: 8] <= d_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/croc_soc_ctrl.sv
// Croc SoC control/status registers: boot address, fetch enable and
// core status / exit code. Single-cycle bus slave, grant is combinational,
// response registered one cycle after acceptance.
// Optional feature macro: SOC_CTRL_SCRATCH_EN adds SCRATCH0..3 at 0x10-0x1C.
module croc_soc_ctrl import croc_soc_ctrl_pkg::*; #(
    parameter logic [31:0] BootAddrDefault = croc_soc_ctrl_pkg::BootAddrDefault,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    input  logic                   fetch_en_i,
    output logic                   fetch_en_o,
    output logic [31:0]            boot_addr_o,
    output logic                   status_o
);

    logic [2:0]     word_idx;
    logic           wr_acc;
    logic           sel_boot, sel_fetch, sel_status;
    logic           addr_err;
    logic [31:0]    rd_data;
    logic [31:0]    boot_addr_q, fetch_en_q, core_status_q;
    soc_ctrl_regs_t regs;
    soc_ctrl_rsp_t  rsp_q;
    logic           status_q;
    logic           unused_addr;

    assign word_idx    = addr_i[4:2];
    assign wr_acc      = req_i & we_i;
    // Base-address decode is done by the interconnect; remaining bits are don't-care
    assign unused_addr = ^{addr_i[AddrWidth-1:5], addr_i[1:0]};

    assign regs = '{boot_addr: boot_addr_q, fetch_en: fetch_en_q, core_status: core_status_q};

`ifdef SOC_CTRL_SCRATCH_EN
    logic [SocCtrlNumScratch-1:0]       sel_scratch;
    logic [SocCtrlNumScratch-1:0][31:0] scratch_q;
`endif

    // Address decode: register selects, read mux and unmapped-offset error
    always_comb begin
        sel_boot   = 1'b0;
        sel_fetch  = 1'b0;
        sel_status = 1'b0;
        rd_data    = '0;
        addr_err   = 1'b0;
`ifdef SOC_CTRL_SCRATCH_EN
        sel_scratch = '0;
`endif
        case (word_idx)
            SOC_CTRL_BOOTADDR_IDX: begin
                sel_boot = 1'b1;
                rd_data  = regs.boot_addr;
            end
            SOC_CTRL_FETCHEN_IDX: begin
                sel_fetch = 1'b1;
                rd_data   = regs.fetch_en;
            end
            SOC_CTRL_CORESTATUS_IDX: begin
                sel_status = 1'b1;
                rd_data    = regs.core_status;
            end
            default: begin
`ifdef SOC_CTRL_SCRATCH_EN
                if (word_idx >= SOC_CTRL_SCRATCH0_IDX) begin
                    sel_scratch[word_idx[1:0]] = 1'b1;
                    rd_data                    = scratch_q[word_idx[1:0]];
                end else begin
                    addr_err = 1'b1;
                end
`else
                addr_err = 1'b1;
`endif
            end
        endcase
    end

    croc_soc_ctrl_reg #(.RstVal(BootAddrDefault)) i_bootaddr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (wr_acc & sel_boot),
        .be_i   (be_i),
        .d_i    (wdata_i),
        .q_o    (boot_addr_q)
    );

    // Only bit 0 is architectural; upper bits are written as 0 so they read 0
    croc_soc_ctrl_reg #(.RstVal(32'h0)) i_fetchen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (wr_acc & sel_fetch),
        .be_i   (be_i),
        .d_i    ({31'b0, wdata_i[0]}),
        .q_o    (fetch_en_q)
    );

    croc_soc_ctrl_reg #(.RstVal(32'h0)) i_corestatus (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (wr_acc & sel_status),
        .be_i   (be_i),
        .d_i    (wdata_i),
        .q_o    (core_status_q)
    );

`ifdef SOC_CTRL_SCRATCH_EN
    for (genvar gi = 0; gi < SocCtrlNumScratch; gi++) begin : g_scratch
        croc_soc_ctrl_reg #(.RstVal(32'h0)) i_scratch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .we_i   (wr_acc & sel_scratch[gi]),
            .be_i   (be_i),
            .d_i    (wdata_i),
            .q_o    (scratch_q[gi])
        );
    end
`endif

    // Response stage: one cycle after acceptance; writes and errors return 0 data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= '{valid: req_i,
                       err:   req_i & addr_err,
                       rdata: (req_i & ~we_i & ~addr_err) ? rd_data : 32'h0};
        end
    end

    // End-of-computation flag follows CORESTATUS being nonzero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) status_q <= 1'b0;
        else         status_q <= |regs.core_status;
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rsp_q.valid;
    assign rdata_o     = rsp_q.rdata;
    assign err_o       = rsp_q.err;
    assign fetch_en_o  = fetch_en_i | regs.fetch_en[0];
    assign boot_addr_o = regs.boot_addr;
    assign status_o    = status_q;

endmodule

// File: tb/tb_croc_soc_ctrl.sv
// Self-checking bench for croc_soc_ctrl: directed scenarios plus a
// randomized back-to-back run checked against a word-array model of the map.
module tb_croc_soc_ctrl;
    import croc_soc_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef SOC_CTRL_SCRATCH_EN
    localparam bit HAS_SCRATCH = 1'b1;
`else
    localparam bit HAS_SCRATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        fetch_en_in, fetch_en_out;
    logic [31:0] boot_addr;
    logic        status;

    int checks = 0;
    int errors = 0;

    croc_soc_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .fetch_en_i  (fetch_en_in),
        .fetch_en_o  (fetch_en_out),
        .boot_addr_o (boot_addr),
        .status_o    (status)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: eight words behind the base ----------------
    logic [31:0] mem [8];
    bit          status_exp;

    function automatic bit is_mapped(input logic [31:0] a);
        int idx = int'(a[4:2]);
        return (idx < 3) || (HAS_SCRATCH && idx >= 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return is_mapped(a) ? mem[int'(a[4:2])] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[0]     = 32'h1000_0000;
        status_exp = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int idx = int'(a[4:2]);
        if (!is_mapped(a)) return;
        for (int k = 0; k < 4; k++)
            if (b[k]) mem[idx][8*k +: 8] = d[8*k +: 8];
        if (idx == 1) mem[1] = mem[1] & 32'h1;
    endtask

    // One bus cycle: drive, sample grant, cross the edge, sample the response
    task automatic bus_cycle(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, output bit g, output bit rv,
                             output logic [31:0] rd, output bit er);
        req = r; we = w; addr = a; be = b; wdata = d;
        #1 g = gnt;
        @(posedge clk);
        status_exp = (mem[2] != 32'h0);
        if (r && w) model_write(a, b, d);
        #1;
        rv = rvalid; rd = rdata; er = err;
        req = 1'b0; we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit g, rv, er; logic [31:0] rd;
        logic [31:0] exp_rd [3];
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; fetch_en_in = 1'b0;
        model_reset();
        #12;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
        checks++; if (status !== 1'b0) begin errors++; $display("FAIL reset_status got %b want 0", status); end
        checks++; if (boot_addr !== 32'h1000_0000) begin errors++; $display("FAIL reset_boot_addr got %h want 10000000", boot_addr); end
        checks++; if (fetch_en_out !== 1'b0) begin errors++; $display("FAIL reset_fetch_en got %b want 0", fetch_en_out); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_rd[0] = 32'h1000_0000; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            bus_cycle(1'b1, 1'b0, BASE + 32'(4*i), 4'hF, 32'h0, g, rv, rd, er);
            checks++; if (g !== 1'b1) begin errors++; $display("FAIL reset_read%0d_gnt got %b want 1", i, g); end
            checks++; if (rv !== 1'b1 || rd !== exp_rd[i] || er !== 1'b0)
                begin errors++; $display("FAIL reset_read%0d got rv=%b data=%h err=%b want rv=1 data=%h err=0", i, rv, rd, er, exp_rd[i]); end
        end
    endtask

    task automatic test_corestatus();
        bit g, rv, er; logic [31:0] rd;
        bus_cycle(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h1234_5678, g, rv, rd, er);
        checks++; if (rv !== 1'b1 || rd !== 32'h0 || er !== 1'b0)
            begin errors++; $display("FAIL status_write_rsp got rv=%b data=%h err=%b want rv=1 data=0 err=0", rv, rd, er); end
        bus_cycle(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, g, rv, rd, er);
        checks++; if (rv !== 1'b1 || rd !== 32'h1234_5678)
            begin errors++; $display("FAIL status_readback got rv=%b data=%h want rv=1 data=12345678", rv, rd); end
        checks++; if (status !== 1'b1) begin errors++; $display("FAIL status_o_set got %b want 1", status); end
        bus_cycle(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h0, g, rv, rd, er);
        bus_cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (status !== 1'b0) begin errors++; $display("FAIL status_o_clear got %b want 0", status); end
    endtask

    task automatic test_fetch_en();
        bit g, rv, er; logic [31:0] rd;
        fetch_en_in = 1'b0;
        bus_cycle(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'hFFFF_FFFF, g, rv, rd, er);
        checks++; if (fetch_en_out !== 1'b1) begin errors++; $display("FAIL fetch_en_sw_set got %b want 1", fetch_en_out); end
        bus_cycle(1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL fetch_en_readback got %h want 00000001", rd); end
        bus_cycle(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'h0, g, rv, rd, er);
        checks++; if (fetch_en_out !== 1'b0) begin errors++; $display("FAIL fetch_en_sw_clear got %b want 0", fetch_en_out); end
        fetch_en_in = 1'b1; #1;
        checks++; if (fetch_en_out !== 1'b1) begin errors++; $display("FAIL fetch_en_pad got %b want 1", fetch_en_out); end
        fetch_en_in = 1'b0;
    endtask

    task automatic test_bootaddr_be();
        bit g, rv, er; logic [31:0] rd;
        bus_cycle(1'b1, 1'b1, BASE, 4'h3, 32'hAABB_CCDD, g, rv, rd, er);
        bus_cycle(1'b1, 1'b0, BASE, 4'hF, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h1000_CCDD) begin errors++; $display("FAIL bootaddr_be_read got %h want 1000ccdd", rd); end
        checks++; if (boot_addr !== 32'h1000_CCDD) begin errors++; $display("FAIL bootaddr_be_out got %h want 1000ccdd", boot_addr); end
    endtask

    task automatic test_unmapped();
        bit g, rv, er; logic [31:0] rd;
        logic [31:0] a;
        bit          exp_err;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? BASE + 32'hC : BASE + 32'h10;
            exp_err = !is_mapped(a);
            bus_cycle(1'b1, 1'b1, a, 4'hF, 32'hDEAD_BEEF, g, rv, rd, er);
            checks++; if (rv !== 1'b1 || er !== exp_err || rd !== 32'h0)
                begin errors++; $display("FAIL unmapped_write_%h got rv=%b err=%b data=%h want rv=1 err=%b data=0", a, rv, er, rd, exp_err); end
            bus_cycle(1'b1, 1'b0, a, 4'hF, 32'h0, g, rv, rd, er);
            checks++; if (rv !== 1'b1 || er !== exp_err || rd !== model_read(a))
                begin errors++; $display("FAIL unmapped_read_%h got rv=%b err=%b data=%h want rv=1 err=%b data=%h", a, rv, er, rd, exp_err, model_read(a)); end
        end
        for (int i = 0; i < 3; i++) begin
            bus_cycle(1'b1, 1'b0, BASE + 32'(4*i), 4'hF, 32'h0, g, rv, rd, er);
            checks++; if (rd !== mem[i] || er !== 1'b0)
                begin errors++; $display("FAIL unmapped_side_effect reg%0d got %h err=%b want %h err=0", i, rd, er, mem[i]); end
        end
    endtask

`ifdef SOC_CTRL_SCRATCH_EN
    task automatic test_scratch();
        bit g, rv, er; logic [31:0] rd;
        bus_cycle(1'b1, 1'b1, BASE + 32'h18, 4'hF, 32'hCAFE_F00D, g, rv, rd, er);
        bus_cycle(1'b1, 1'b0, BASE + 32'h18, 4'hF, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0)
            begin errors++; $display("FAIL scratch2_readback got %h err=%b want cafef00d err=0", rd, er); end
    endtask
`endif

    task automatic test_back_to_back();
        bit g, rv, er; logic [31:0] rd;
        bit r, w;
        logic [31:0] a, d, exp_rd;
        logic [3:0]  b;
        bit          exp_err;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 9) < 7);
            w = $urandom_range(0, 1);
            a = BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            b = 4'($urandom);
            d = $urandom;
            fetch_en_in = $urandom_range(0, 1);
            exp_rd  = w ? 32'h0 : model_read(a);
            exp_err = !is_mapped(a);
            bus_cycle(r, w, a, b, d, g, rv, rd, er);
            checks++; if (g !== r) begin errors++; $display("FAIL b2b_gnt n=%0d got %b want %b", n, g, r); end
            checks++; if (rv !== r) begin errors++; $display("FAIL b2b_rvalid n=%0d got %b want %b", n, rv, r); end
            if (r) begin
                checks++; if (rd !== exp_rd || er !== exp_err)
                    begin errors++; $display("FAIL b2b_rsp n=%0d we=%b addr=%h got data=%h err=%b want data=%h err=%b", n, w, a, rd, er, exp_rd, exp_err); end
            end
            checks++; if (boot_addr !== mem[0]) begin errors++; $display("FAIL b2b_boot_addr n=%0d got %h want %h", n, boot_addr, mem[0]); end
            checks++; if (status !== status_exp) begin errors++; $display("FAIL b2b_status n=%0d got %b want %b", n, status, status_exp); end
            checks++; if (fetch_en_out !== (fetch_en_in | mem[1][0]))
                begin errors++; $display("FAIL b2b_fetch_en n=%0d got %b want %b", n, fetch_en_out, fetch_en_in | mem[1][0]); end
        end
        fetch_en_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit g, rv, er; logic [31:0] rd;
        bus_cycle(1'b1, 1'b1, BASE,         4'hF, 32'h2000_0000, g, rv, rd, er);
        bus_cycle(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'h1,         g, rv, rd, er);
        bus_cycle(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h5,         g, rv, rd, er);
        fetch_en_in = 1'b0;
        // read accepted at the next edge, reset hits in the response cycle
        req = 1'b1; we = 1'b0; addr = BASE; be = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        model_reset();
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b want 0", rvalid); end
        checks++; if (boot_addr !== 32'h1000_0000) begin errors++; $display("FAIL rstmid_boot_addr got %h want 10000000", boot_addr); end
        checks++; if (fetch_en_out !== 1'b0) begin errors++; $display("FAIL rstmid_fetch_en got %b want 0", fetch_en_out); end
        checks++; if (status !== 1'b0) begin errors++; $display("FAIL rstmid_status got %b want 0", status); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid_held got %b want 0", rvalid); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus_cycle(1'b1, 1'b0, BASE + 32'(4*i), 4'hF, 32'h0, g, rv, rd, er);
            checks++; if (rv !== 1'b1 || rd !== mem[i])
                begin errors++; $display("FAIL rstmid_reg%0d got rv=%b data=%h want rv=1 data=%h", i, rv, rd, mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_corestatus();
        test_fetch_en();
        test_bootaddr_be();
        test_unmapped();
`ifdef SOC_CTRL_SCRATCH_EN
        test_scratch();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
